// File: rtl/mmio_axi_master_pkg.sv
// Shared AXI constants, FSM state encoding and response-check helper for the
// MMIO-to-AXI single-beat bridge.
package mmio_axi_master_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [7:0] LEN_SINGLE  = 8'd0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_D = 3'd2,
        S_WR   = 3'd3,
        S_WR_B = 3'd4,
        S_RESP = 3'd5
    } state_e;

    // A response is bad when it is not OKAY or carries a foreign ID.
    function automatic logic resp_bad(input logic [1:0] resp, input logic id_ok);
        return (resp != RESP_OKAY) || !id_ok;
    endfunction

endpackage

// File: rtl/mmio_axi_master_if.sv
// MMIO request/response port plus the AXI4 AR/R/AW/W/B channel set toward the
// UART responder; master is the bridge's view, slave the core/responder view.
interface mmio_axi_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wmask;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;

    logic [ID_W-1:0]       io_uart_ar_id;
    logic [ADDR_W-1:0]     io_uart_ar_addr;
    logic [7:0]            io_uart_ar_len;
    logic [2:0]            io_uart_ar_size;
    logic [1:0]            io_uart_ar_burst;
    logic                  io_uart_ar_valid;
    logic                  io_uart_ar_ready;
    logic [ID_W-1:0]       io_uart_r_id;
    logic [1:0]            io_uart_r_resp;
    logic [DATA_W-1:0]     io_uart_r_data;
    logic                  io_uart_r_last;
    logic                  io_uart_r_valid;
    logic                  io_uart_r_ready;
    logic [ID_W-1:0]       io_uart_aw_id;
    logic [ADDR_W-1:0]     io_uart_aw_addr;
    logic [7:0]            io_uart_aw_len;
    logic [2:0]            io_uart_aw_size;
    logic [1:0]            io_uart_aw_burst;
    logic                  io_uart_aw_valid;
    logic                  io_uart_aw_ready;
    logic [DATA_W-1:0]     io_uart_w_data;
    logic [DATA_W/8-1:0]   io_uart_w_strb;
    logic                  io_uart_w_last;
    logic                  io_uart_w_valid;
    logic                  io_uart_w_ready;
    logic [ID_W-1:0]       io_uart_b_id;
    logic [1:0]            io_uart_b_resp;
    logic                  io_uart_b_valid;
    logic                  io_uart_b_ready;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output io_uart_ar_id, io_uart_ar_addr, io_uart_ar_len, io_uart_ar_size,
               io_uart_ar_burst, io_uart_ar_valid,
        input  io_uart_ar_ready,
        input  io_uart_r_id, io_uart_r_resp, io_uart_r_data, io_uart_r_last, io_uart_r_valid,
        output io_uart_r_ready,
        output io_uart_aw_id, io_uart_aw_addr, io_uart_aw_len, io_uart_aw_size,
               io_uart_aw_burst, io_uart_aw_valid,
        input  io_uart_aw_ready,
        output io_uart_w_data, io_uart_w_strb, io_uart_w_last, io_uart_w_valid,
        input  io_uart_w_ready,
        input  io_uart_b_id, io_uart_b_resp, io_uart_b_valid,
        output io_uart_b_ready
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  io_uart_ar_id, io_uart_ar_addr, io_uart_ar_len, io_uart_ar_size,
               io_uart_ar_burst, io_uart_ar_valid,
        output io_uart_ar_ready,
        output io_uart_r_id, io_uart_r_resp, io_uart_r_data, io_uart_r_last, io_uart_r_valid,
        input  io_uart_r_ready,
        input  io_uart_aw_id, io_uart_aw_addr, io_uart_aw_len, io_uart_aw_size,
               io_uart_aw_burst, io_uart_aw_valid,
        output io_uart_aw_ready,
        input  io_uart_w_data, io_uart_w_strb, io_uart_w_last, io_uart_w_valid,
        output io_uart_w_ready,
        output io_uart_b_id, io_uart_b_resp, io_uart_b_valid,
        input  io_uart_b_ready
    );

endinterface

// File: rtl/mmio_axi_master.sv
// Bridges the core MMIO request/response port to a single-beat AXI4 initiator
// with one transaction outstanding; all bus outputs come straight from flops.
module mmio_axi_master
    import mmio_axi_master_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 8,
    parameter int AXI_ID = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    mmio_axi_master_if.master  bus
);

    localparam int              STRB_W = DATA_W / 8;
    localparam logic [ID_W-1:0] LP_ID  = ID_W'(AXI_ID);

    state_e              r_state;
    state_e              w_state_nxt;
    logic                r_req_ready;
    logic                r_ar_valid;
    logic                r_r_ready;
    logic                r_aw_valid;
    logic                r_w_valid;
    logic                r_b_ready;
    logic                r_resp_valid;
    logic [DATA_W-1:0]   r_resp_rdata;
    logic                r_resp_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wmask;

    logic w_accept;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_aw_done;
    logic w_w_done;
    logic w_b_hs;
    logic w_resp_hs;

    assign w_accept  = bus.req_valid && r_req_ready;
    assign w_ar_hs   = r_ar_valid && bus.io_uart_ar_ready;
    assign w_r_hs    = r_r_ready && bus.io_uart_r_valid;
    assign w_aw_done = !r_aw_valid || bus.io_uart_aw_ready;
    assign w_w_done  = !r_w_valid || bus.io_uart_w_ready;
    assign w_b_hs    = r_b_ready && bus.io_uart_b_valid;
    assign w_resp_hs = r_resp_valid && bus.resp_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = bus.req_we ? S_WR : S_RD_A;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD_A: w_state_nxt = w_ar_hs ? S_RD_D : S_RD_A;
            S_RD_D: w_state_nxt = w_r_hs ? S_RESP : S_RD_D;
            S_WR:   w_state_nxt = (w_aw_done && w_w_done) ? S_WR_B : S_WR;
            S_WR_B: w_state_nxt = w_b_hs ? S_RESP : S_WR_B;
            S_RESP: w_state_nxt = w_resp_hs ? S_IDLE : S_RESP;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered handshakes, request capture and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready  <= 1'b0;
            r_ar_valid   <= 1'b0;
            r_r_ready    <= 1'b0;
            r_aw_valid   <= 1'b0;
            r_w_valid    <= 1'b0;
            r_b_ready    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= {DATA_W{1'b0}};
            r_resp_err   <= 1'b0;
            r_addr       <= {ADDR_W{1'b0}};
            r_wdata      <= {DATA_W{1'b0}};
            r_wmask      <= {STRB_W{1'b0}};
        end else begin
            r_req_ready  <= (w_state_nxt == S_IDLE);
            r_ar_valid   <= (w_state_nxt == S_RD_A);
            r_r_ready    <= (w_state_nxt == S_RD_D);
            r_b_ready    <= (w_state_nxt == S_WR_B);
            r_resp_valid <= (w_state_nxt == S_RESP);
            // AW and W retire independently; each holds until its own ready.
            r_aw_valid   <= (w_accept && bus.req_we) || (r_aw_valid && !bus.io_uart_aw_ready);
            r_w_valid    <= (w_accept && bus.req_we) || (r_w_valid && !bus.io_uart_w_ready);
            if (w_accept) begin
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_wmask <= bus.req_wmask;
            end
            if (w_r_hs) begin
                r_resp_rdata <= bus.io_uart_r_data;
                r_resp_err   <= resp_bad(bus.io_uart_r_resp, bus.io_uart_r_id == LP_ID)
                                || !bus.io_uart_r_last;
            end else if (w_b_hs) begin
                r_resp_rdata <= {DATA_W{1'b0}};
                r_resp_err   <= resp_bad(bus.io_uart_b_resp, bus.io_uart_b_id == LP_ID);
            end
        end
    end

    assign bus.req_ready        = r_req_ready;
    assign bus.resp_valid       = r_resp_valid;
    assign bus.resp_rdata       = r_resp_rdata;
    assign bus.resp_err         = r_resp_err;
    assign bus.io_uart_ar_id    = LP_ID;
    assign bus.io_uart_ar_addr  = r_addr;
    assign bus.io_uart_ar_len   = LEN_SINGLE;
    assign bus.io_uart_ar_size  = SIZE_4B;
    assign bus.io_uart_ar_burst = BURST_INCR;
    assign bus.io_uart_ar_valid = r_ar_valid;
    assign bus.io_uart_r_ready  = r_r_ready;
    assign bus.io_uart_aw_id    = LP_ID;
    assign bus.io_uart_aw_addr  = r_addr;
    assign bus.io_uart_aw_len   = LEN_SINGLE;
    assign bus.io_uart_aw_size  = SIZE_4B;
    assign bus.io_uart_aw_burst = BURST_INCR;
    assign bus.io_uart_aw_valid = r_aw_valid;
    assign bus.io_uart_w_data   = r_wdata;
    assign bus.io_uart_w_strb   = r_wmask;
    assign bus.io_uart_w_last   = 1'b1;
    assign bus.io_uart_w_valid  = r_w_valid;
    assign bus.io_uart_b_ready  = r_b_ready;

endmodule

// File: tb/tb_mmio_axi_master.sv
// Directed bench for mmio_axi_master: the bench plays core and UART responder
// cycle by cycle and compares against hand-computed expectations.
module tb_mmio_axi_master;
    import mmio_axi_master_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    mmio_axi_master_if #(.ADDR_W(32), .DATA_W(32), .ID_W(8)) bus ();

    mmio_axi_master #(.ADDR_W(32), .DATA_W(32), .ID_W(8), .AXI_ID(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] rresp, input logic [7:0] rid, input logic rlast,
                           input logic exp_err, input int stall, input string tag);
        chk_eq($sformatf("%s.req_ready", tag), bus.req_ready, 64'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = addr;
        tick();
        bus.req_valid = 1'b0;
        chk_eq($sformatf("%s.ar_valid", tag), bus.io_uart_ar_valid, 64'd1);
        chk_eq($sformatf("%s.ar_addr", tag),  bus.io_uart_ar_addr, {32'd0, addr});
        chk_eq($sformatf("%s.ar_len", tag),   bus.io_uart_ar_len, 64'd0);
        chk_eq($sformatf("%s.ar_size", tag),  bus.io_uart_ar_size, 64'd2);
        chk_eq($sformatf("%s.ar_burst", tag), bus.io_uart_ar_burst, 64'd1);
        chk_eq($sformatf("%s.ar_id", tag),    bus.io_uart_ar_id, 64'd0);
        chk_eq($sformatf("%s.req_busy", tag), bus.req_ready, 64'd0);
        bus.io_uart_ar_ready = 1'b1;
        tick();
        bus.io_uart_ar_ready = 1'b0;
        chk_eq($sformatf("%s.ar_drop", tag), bus.io_uart_ar_valid, 64'd0);
        chk_eq($sformatf("%s.r_ready", tag), bus.io_uart_r_ready, 64'd1);
        chk_eq($sformatf("%s.early_resp", tag), bus.resp_valid, 64'd0);
        bus.io_uart_r_valid = 1'b1;
        bus.io_uart_r_data  = data;
        bus.io_uart_r_resp  = rresp;
        bus.io_uart_r_id    = rid;
        bus.io_uart_r_last  = rlast;
        tick();
        bus.io_uart_r_valid = 1'b0;
        chk_eq($sformatf("%s.resp_valid", tag), bus.resp_valid, 64'd1);
        chk_eq($sformatf("%s.rdata", tag), bus.resp_rdata, {32'd0, data});
        chk_eq($sformatf("%s.err", tag), bus.resp_err, {63'd0, exp_err});
        chk_eq($sformatf("%s.r_ready_drop", tag), bus.io_uart_r_ready, 64'd0);
        for (int s = 0; s < stall; s++) begin
            bus.req_valid = 1'b1;
            tick();
            chk_eq($sformatf("%s.stall_valid%0d", tag, s), bus.resp_valid, 64'd1);
            chk_eq($sformatf("%s.stall_rdata%0d", tag, s), bus.resp_rdata, {32'd0, data});
            chk_eq($sformatf("%s.stall_rdy%0d", tag, s), bus.req_ready, 64'd0);
            chk_eq($sformatf("%s.stall_ar%0d", tag, s), bus.io_uart_ar_valid, 64'd0);
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        chk_eq($sformatf("%s.resp_done", tag), bus.resp_valid, 64'd0);
        chk_eq($sformatf("%s.req_ready_back", tag), bus.req_ready, 64'd1);
        chk_eq($sformatf("%s.no_accept", tag), bus.io_uart_ar_valid, 64'd0);
        bus.req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask,
                            input int ca, input int cw, input logic [1:0] bresp,
                            input logic [7:0] bid, input logic exp_err, input string tag);
        int last;
        last = (ca > cw) ? ca : cw;
        chk_eq($sformatf("%s.req_ready", tag), bus.req_ready, 64'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        bus.req_wmask = mask;
        tick();
        bus.req_valid = 1'b0;
        bus.req_wdata = 32'h0;
        bus.req_wmask = 4'h0;
        chk_eq($sformatf("%s.aw_addr", tag), bus.io_uart_aw_addr, {32'd0, addr});
        chk_eq($sformatf("%s.aw_fields", tag),
               {bus.io_uart_aw_id, bus.io_uart_aw_len, bus.io_uart_aw_size, bus.io_uart_aw_burst},
               {43'd0, 8'd0, 8'd0, 3'd2, 2'd1});
        for (int k = 1; k <= last; k++) begin
            chk_eq($sformatf("%s.aw_valid%0d", tag, k), bus.io_uart_aw_valid, {63'd0, k <= ca});
            chk_eq($sformatf("%s.w_valid%0d", tag, k), bus.io_uart_w_valid, {63'd0, k <= cw});
            chk_eq($sformatf("%s.w_data%0d", tag, k), bus.io_uart_w_data, {32'd0, data});
            chk_eq($sformatf("%s.w_strb%0d", tag, k), bus.io_uart_w_strb, {60'd0, mask});
            chk_eq($sformatf("%s.w_last%0d", tag, k), bus.io_uart_w_last, 64'd1);
            chk_eq($sformatf("%s.b_ready%0d", tag, k), bus.io_uart_b_ready, 64'd0);
            bus.io_uart_aw_ready = (k == ca);
            bus.io_uart_w_ready  = (k == cw);
            tick();
        end
        bus.io_uart_aw_ready = 1'b0;
        bus.io_uart_w_ready  = 1'b0;
        chk_eq($sformatf("%s.valids_drop", tag),
               {bus.io_uart_aw_valid, bus.io_uart_w_valid}, 64'd0);
        chk_eq($sformatf("%s.b_ready", tag), bus.io_uart_b_ready, 64'd1);
        bus.io_uart_b_valid = 1'b1;
        bus.io_uart_b_resp  = bresp;
        bus.io_uart_b_id    = bid;
        tick();
        bus.io_uart_b_valid = 1'b0;
        chk_eq($sformatf("%s.resp_valid", tag), bus.resp_valid, 64'd1);
        chk_eq($sformatf("%s.rdata_zero", tag), bus.resp_rdata, 64'd0);
        chk_eq($sformatf("%s.err", tag), bus.resp_err, {63'd0, exp_err});
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        chk_eq($sformatf("%s.req_ready_back", tag), bus.req_ready, 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0; bus.req_wmask = 4'h0; bus.resp_ready = 1'b0;
        bus.io_uart_ar_ready = 1'b0; bus.io_uart_aw_ready = 1'b0; bus.io_uart_w_ready = 1'b0;
        bus.io_uart_r_valid = 1'b0; bus.io_uart_r_id = 8'h0; bus.io_uart_r_resp = 2'b00;
        bus.io_uart_r_data = 32'h0; bus.io_uart_r_last = 1'b0;
        bus.io_uart_b_valid = 1'b0; bus.io_uart_b_id = 8'h0; bus.io_uart_b_resp = 2'b00;
        tick();
        tick();
        chk_eq("rst.req_ready", bus.req_ready, 64'd0);
        chk_eq("rst.valids", {bus.io_uart_ar_valid, bus.io_uart_aw_valid, bus.io_uart_w_valid,
                              bus.resp_valid}, 64'd0);
        chk_eq("rst.readies", {bus.io_uart_r_ready, bus.io_uart_b_ready}, 64'd0);
        chk_eq("rst.rdata", bus.resp_rdata, 64'd0);
        chk_eq("rst.err", bus.resp_err, 64'd0);
        chk_eq("rst.addr", bus.io_uart_ar_addr, 64'd0);
        rst_n = 1'b1;
        tick();

        do_read(32'hBFD0_03F8, 32'h0000_0041, RESP_OKAY, 8'h00, 1'b1, 1'b0, 0, "rd_ok");
        do_write(32'hBFD0_03F8, 32'h0000_005A, 4'b0001, 1, 4, RESP_OKAY, 8'h00, 1'b0, "wr_split");
        do_write(32'h1000_0004, 32'hDEAD_BEEF, 4'b1111, 1, 1, RESP_OKAY, 8'h00, 1'b0, "wr_same");
        do_write(32'h1000_0008, 32'h0000_1234, 4'b0011, 3, 2, RESP_SLVERR, 8'h00, 1'b1, "wr_slverr");
        do_write(32'h1000_000C, 32'h8765_4321, 4'b1100, 2, 2, RESP_OKAY, 8'h05, 1'b1, "wr_badid");
        do_read(32'hBFD0_0000, 32'h1234_5678, RESP_SLVERR, 8'h00, 1'b1, 1'b1, 0, "rd_slverr");
        do_read(32'hBFD0_0004, 32'h0000_CAFE, RESP_OKAY, 8'h05, 1'b1, 1'b1, 0, "rd_badid");
        do_read(32'hBFD0_0008, 32'h0000_0077, RESP_OKAY, 8'h00, 1'b0, 1'b1, 0, "rd_nolast");
        do_read(32'hBFD0_000C, 32'hA5A5_0F0F, RESP_OKAY, 8'h00, 1'b1, 1'b0, 5, "rd_stall");

        // Abort a read while it waits in RD_D.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'hBFD0_0010;
        tick();
        bus.req_valid = 1'b0;
        bus.io_uart_ar_ready = 1'b1;
        tick();
        bus.io_uart_ar_ready = 1'b0;
        chk_eq("abort.in_rd_d", bus.io_uart_r_ready, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("abort.readies", {bus.req_ready, bus.io_uart_r_ready, bus.io_uart_b_ready}, 64'd0);
        chk_eq("abort.valids", {bus.io_uart_ar_valid, bus.io_uart_aw_valid, bus.io_uart_w_valid,
                                bus.resp_valid}, 64'd0);
        chk_eq("abort.addr", bus.io_uart_ar_addr, 64'd0);
        chk_eq("abort.rdata", bus.resp_rdata, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_read(32'hBFD0_03F8, 32'h0000_0042, RESP_OKAY, 8'h00, 1'b1, 1'b0, 0, "rd_after_rst");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/mmio_axi_master.md
Name: mmio_axi_master

Overview:
- Bridges the core's simple MMIO request/response port to a single-beat AXI4 initiator.
- Drives the same AXI channel set the UART responder consumes (AR/R/AW/W/B).
- One transaction outstanding at a time; writes present AW and W together.
- Sits between the CPU data path and uart_wrapper in clk_150M domain.

Parameters:
- ADDR_W, 32, AXI/request address width
- DATA_W, 32, data width; strobe width DATA_W/8
- ID_W, 8, AXI ID width
- AXI_ID, 0, constant ID driven on ar_id/aw_id and expected on r_id/b_id

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_wmask  in  DATA_W/8  byte strobes
- resp_valid  out  1  response available
- resp_ready  in  1  response consumed
- resp_rdata  out  DATA_W  read data (0 for writes)
- resp_err  out  1  1 on non-OKAY resp or ID mismatch
- io_uart_ar_*  out  id/addr/len/size/burst/valid; ar_ready in
- io_uart_r_*  in  id/resp/data/last/valid; r_ready out
- io_uart_aw_*  out  id/addr/len/size/burst/valid; aw_ready in
- io_uart_w_*  out  data/strb/last/valid; w_ready in
- io_uart_b_*  in  id/resp/valid; b_ready out

Behaviour:
- Reset (async assert, sync-deasserted use): state IDLE; all valids/readies 0; resp_rdata 0; resp_err 0; address/data regs 0.
- Constant fields: len=0, size=3'b010, burst=2'b01, w_last=1, ids=AXI_ID.
- States: IDLE, RD_A, RD_D, WR, WR_B, RESP.
- IDLE: req_ready=1. On req_valid, latch addr/wdata/wmask/we.
  - Read: go RD_A with ar_valid=1 next cycle.
  - Write: go WR with aw_valid=w_valid=1.
- RD_A: hold ar_valid and ar_addr stable until ar_ready. Then go RD_D, r_ready=1.
- RD_D: on r_valid, capture r_data. Set err = (r_resp!=0) | (r_id!=AXI_ID) | !r_last. Go RESP.
- WR:
  - aw_valid and w_valid drop independently, each on its own ready.
  - Leave for WR_B (b_ready=1) once both are accepted. Acceptance on the same or different cycles are both legal.
  - Payloads stay stable while their valid is high.
- WR_B: on b_valid, err = (b_resp!=0) | (b_id!=AXI_ID). resp_rdata=0. Go RESP.
- RESP: resp_valid=1 until resp_ready, then IDLE.
  - req_ready stays 0 until IDLE, so minimum read latency is req accept -> resp_valid in 3 cycles with zero-wait responder.
- Responses that arrive early (r_valid/b_valid) before r_ready/b_ready are held by the responder per AXI, never dropped.
- Unexpected r_valid/b_valid outside RD_D/WR_B: ignored, since ready is 0.
- No AXI valid deasserts without its handshake. Reset mid-transaction aborts to IDLE; the responder is reset by the same reset.

Decomposition:
- Shared package: AXI constants (BURST_INCR=2'b01, SIZE_4B=3'b010, RESP_OKAY=2'b00, RESP_SLVERR=2'b10) and the state encoding enum.
- No sub-module required. Optionally a one-entry response register (mmio_resp_reg) may be split out.

Test Plan:
- Read 0xBFD003F8, responder ar_ready=1 immediately, r_valid next cycle with data 0x00000041, resp OKAY -> resp_valid 3 cycles after accept, resp_rdata=0x41, resp_err=0, ar_len=0, ar_size=2.
- Write 0xBFD003F8 data 0x5A mask 4'b0001; aw_ready at cycle 1, w_ready at cycle 4 -> aw_valid drops after cycle 1, w_valid held with w_data=0x5A, w_strb=0001 until cycle 4, then b OKAY -> resp_err=0.
- Write with aw_ready and w_ready in the same cycle -> both valids drop together; enter WR_B next cycle.
- Read with r_resp=2'b10 or r_id=0x05 -> resp_err=1, resp_rdata=returned data.
- resp_ready held 0 for 5 cycles -> resp_valid and data stable, req_ready=0; new req_valid is not accepted until the cycle after resp_ready.
- rst_n pulsed low in RD_D -> all outputs 0 immediately (asynchronous); after release, next read completes normally.
